// File: rtl/data_mem_if.sv
// CPU MEM-stage bus into the data memory unit.
//   mem_w_en : store strobe
//   addr     : byte address, shared by loads and stores
//   w_data   : store data
//   r_data   : load data, combinational from addr and current state
// The master modport is the CPU side; the slave modport is the memory unit.
interface data_mem_if;
  logic        mem_w_en;
  logic [31:0] addr;
  logic [31:0] w_data;
  logic [31:0] r_data;

  modport master (output mem_w_en, output addr, output w_data, input r_data);
  modport slave  (input mem_w_en, input addr, input w_data, output r_data);
endinterface

// File: rtl/data_mem_unit.sv
// Data memory unit for a simple CPU: a word RAM plus a small block of
// memory-mapped peripherals.
//   0x0000_0000 .. RAM_WORDS*4-1 : data RAM, zero-latency load
//   0x8000_0000 GPIO   : output register driving gpio_out
//   0x8000_0004 TXDATA : store pushes w_data[7:0] into the TX FIFO, load is 0
//   0x8000_0008 TXSTAT : {overflow[8], count[7:2], empty[1], full[0]};
//                        any store clears overflow
//   0x8000_000C CYCLE  : free-running cycle counter; a store zeroes it
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   bus            : CPU load/store bus (data_mem_if.slave)
//   gpio_out       : GPIO output register
//   tx_data        : TX FIFO head byte (meaningful only while tx_valid)
//   tx_valid       : TX FIFO non-empty
//   tx_ready       : consumer takes the head on a clock edge with tx_valid
//   err_misaligned : sticky flag, set by a misaligned store to a mapped word
module data_mem_unit #(
  parameter int RAM_WORDS = 256,
  parameter int TX_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  data_mem_if.slave        bus,
  output logic [31:0]      gpio_out,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             err_misaligned
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;

  // Peripheral word addresses (byte address >> 2).
  localparam logic [29:0] GPIO_WORD = 30'h2000_0000;
  localparam logic [29:0] TXD_WORD  = 30'h2000_0001;
  localparam logic [29:0] TXS_WORD  = 30'h2000_0002;
  localparam logic [29:0] CYC_WORD  = 30'h2000_0003;

  // Storage
  logic [31:0]   ram_q  [RAM_WORDS];
  logic [7:0]    fifo_q [TX_DEPTH];

  // Registers
  logic [31:0]   gpio_q,   gpio_d;
  logic [31:0]   cycle_q,  cycle_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          ovf_q,    ovf_d;
  logic          err_q,    err_d;

  // Decode
  logic [29:0]   word_addr;
  logic [AW-1:0] ram_idx;
  logic          is_ram, is_gpio, is_txd, is_txs, is_cyc, mapped;
  logic          aligned, store_ok, ram_we;
  logic          full, empty, pop, push_req, push;
  logic [31:0]   tx_status;

  assign word_addr = bus.addr[31:2];
  assign ram_idx   = bus.addr[AW+1:2];
  assign is_ram    = (bus.addr[31:AW+2] == '0);
  assign is_gpio   = (word_addr == GPIO_WORD);
  assign is_txd    = (word_addr == TXD_WORD);
  assign is_txs    = (word_addr == TXS_WORD);
  assign is_cyc    = (word_addr == CYC_WORD);
  assign mapped    = is_ram | is_gpio | is_txd | is_txs | is_cyc;
  assign aligned   = (bus.addr[1:0] == 2'b00);

  // A misaligned store is dropped entirely; only aligned stores change state.
  assign store_ok  = bus.mem_w_en && aligned;
  assign ram_we    = store_ok && is_ram;

  assign full      = (count_q == CW'(TX_DEPTH));
  assign empty     = (count_q == '0);
  assign pop       = !empty && tx_ready;
  assign push_req  = store_ok && is_txd;
  // When full, a same-cycle pop frees the slot the push needs.
  assign push      = push_req && (!full || pop);

  assign tx_status = {23'd0, ovf_q, 6'(count_q), empty, full};

  // NOTE: combinational blocks use blocking assignments, and every output is
  // given a default first so no latch can be inferred on an unassigned path.
  always_comb begin
    gpio_d   = gpio_q;
    ovf_d    = ovf_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    cycle_d  = cycle_q + 32'd1;

    if (store_ok && is_gpio) gpio_d  = bus.w_data;
    if (store_ok && is_cyc)  cycle_d = '0;

    if (push_req && !push)     ovf_d = 1'b1;
    else if (store_ok && is_txs) ovf_d = 1'b0;

    // Pointers are PW bits wide, so the increment wraps modulo TX_DEPTH.
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);

    if (bus.mem_w_en && !aligned && mapped) err_d = 1'b1;
  end

  // Load path: zero latency; address bits [1:0] are ignored.
  always_comb begin
    bus.r_data = '0;
    if (is_ram)       bus.r_data = ram_q[ram_idx];
    else if (is_gpio) bus.r_data = gpio_q;
    else if (is_txs)  bus.r_data = tx_status;
    else if (is_cyc)  bus.r_data = cycle_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_q   <= '0;
      cycle_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      gpio_q   <= gpio_d;
      cycle_q  <= cycle_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  // NOTE: storage arrays have no reset, which lets them map onto RAM
  // macros; clearing the FIFO pointers is enough to discard its contents.
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= bus.w_data;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= bus.w_data[7:0];
  end

  assign gpio_out       = gpio_q;
  assign tx_valid       = !empty;
  assign tx_data        = fifo_q[rd_ptr_q];
  assign err_misaligned = err_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed self-checking bench for data_mem_unit (default parameters).
// Inputs change just after the falling edge; outputs are checked 1 ns later,
// so combinational loads see pre-edge state and registered effects of the
// previous cycle's store are visible.
module tb_data_mem_unit;

  localparam logic [31:0] GPIO_A = 32'h8000_0000;
  localparam logic [31:0] TXD_A  = 32'h8000_0004;
  localparam logic [31:0] TXS_A  = 32'h8000_0008;
  localparam logic [31:0] CYC_A  = 32'h8000_000C;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] gpio_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        err_misaligned;

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_if bus ();

  data_mem_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .gpio_out       (gpio_out),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .err_misaligned (err_misaligned)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.mem_w_en = we;
    bus.addr     = a;
    bus.w_data   = d;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tx_ready = 1'b0;
    bus.mem_w_en = 1'b0; bus.addr = TXS_A; bus.w_data = '0;
    #1;
    n_checks++; if (gpio_out !== 32'h0) begin n_fail++; $display("FAIL reset_gpio: got %h expected %h", gpio_out, 32'h0); end
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    n_checks++; if (err_misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err_misaligned); end
    n_checks++; if (bus.r_data !== 32'h2) begin n_fail++; $display("FAIL reset_txstat: got %h expected %h", bus.r_data, 32'h2); end
    @(negedge clk);
    bus.addr = CYC_A;
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus.r_data !== 32'd0) begin n_fail++; $display("FAIL cycle_first: got %h expected 0", bus.r_data); end
    drive(1'b0, CYC_A, '0);
    n_checks++; if (bus.r_data !== 32'd1) begin n_fail++; $display("FAIL cycle_second: got %h expected 1", bus.r_data); end
  endtask

  task automatic test_ram();
    drive(1'b1, 32'h10, 32'h1111_1111);
    drive(1'b1, 32'h10, 32'hDEAD_BEEF);
    n_checks++; if (bus.r_data !== 32'h1111_1111) begin n_fail++; $display("FAIL ram_same_cycle_old: got %h expected %h", bus.r_data, 32'h1111_1111); end
    drive(1'b0, 32'h10, '0);
    n_checks++; if (bus.r_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_readback: got %h expected %h", bus.r_data, 32'hDEAD_BEEF); end
    drive(1'b1, 32'h3FC, 32'h0BAD_F00D);
    drive(1'b0, 32'h3FC, '0);
    n_checks++; if (bus.r_data !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL ram_last_word: got %h expected %h", bus.r_data, 32'h0BAD_F00D); end
    drive(1'b0, 32'h12, '0);
    n_checks++; if (bus.r_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_misaligned_load: got %h expected %h", bus.r_data, 32'hDEAD_BEEF); end
    drive(1'b0, 32'h400, '0);
    n_checks++; if (bus.r_data !== 32'h0) begin n_fail++; $display("FAIL unmapped_past_ram: got %h expected 0", bus.r_data); end
  endtask

  task automatic test_gpio_misaligned();
    drive(1'b1, GPIO_A, 32'h1234);
    drive(1'b0, GPIO_A, '0);
    n_checks++; if (gpio_out !== 32'h1234) begin n_fail++; $display("FAIL gpio_out: got %h expected %h", gpio_out, 32'h1234); end
    n_checks++; if (bus.r_data !== 32'h1234) begin n_fail++; $display("FAIL gpio_load: got %h expected %h", bus.r_data, 32'h1234); end
    drive(1'b1, 32'h8000_0010, 32'h5);
    drive(1'b0, 32'h8000_0010, '0);
    n_checks++; if (bus.r_data !== 32'h0) begin n_fail++; $display("FAIL unmapped_load: got %h expected 0", bus.r_data); end
    n_checks++; if (err_misaligned !== 1'b0) begin n_fail++; $display("FAIL unmapped_store_err: got %b expected 0", err_misaligned); end
    drive(1'b1, 32'h13, 32'hCAFE_F00D);
    drive(1'b1, 32'h8000_0001, 32'hFFFF_FFFF);
    n_checks++; if (err_misaligned !== 1'b1) begin n_fail++; $display("FAIL misaligned_err: got %b expected 1", err_misaligned); end
    drive(1'b0, 32'h10, '0);
    n_checks++; if (bus.r_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL misaligned_ram_kept: got %h expected %h", bus.r_data, 32'hDEAD_BEEF); end
    n_checks++; if (gpio_out !== 32'h1234) begin n_fail++; $display("FAIL misaligned_gpio_kept: got %h expected %h", gpio_out, 32'h1234); end
    drive(1'b0, 32'h10, '0);
    n_checks++; if (err_misaligned !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", err_misaligned); end
  endtask

  task automatic test_fifo_overflow();
    logic [7:0] exp_b;
    tx_ready = 1'b0;
    drive(1'b1, TXD_A, 32'h41);
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL push_no_bypass: got %b expected 0", tx_valid); end
    drive(1'b1, TXD_A, 32'h42);
    n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin n_fail++; $display("FAIL push_head: got v=%b d=%h expected v=1 d=41", tx_valid, tx_data); end
    drive(1'b1, TXD_A, 32'h43);
    drive(1'b1, TXD_A, 32'h44);
    drive(1'b1, TXD_A, 32'h45);
    // full(1) | count 4 << 2 (0x10) | overflow (0x100)
    drive(1'b0, TXS_A, '0);
    n_checks++; if (bus.r_data !== 32'h111) begin n_fail++; $display("FAIL txstat_overflow: got %h expected %h", bus.r_data, 32'h111); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, TXD_A, '0);
      tx_ready = 1'b1;
      exp_b = 8'h41 + 8'(i);
      n_checks++; if (tx_valid !== 1'b1 || tx_data !== exp_b) begin n_fail++; $display("FAIL drain_%0d: got v=%b d=%h expected v=1 d=%h", i, tx_valid, tx_data, exp_b); end
    end
    n_checks++; if (bus.r_data !== 32'h0) begin n_fail++; $display("FAIL txdata_load: got %h expected 0", bus.r_data); end
    drive(1'b0, TXS_A, '0);
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL drained_valid: got %b expected 0", tx_valid); end
    n_checks++; if (bus.r_data !== 32'h102) begin n_fail++; $display("FAIL txstat_ovf_empty: got %h expected %h", bus.r_data, 32'h102); end
    drive(1'b1, TXS_A, 32'hFFFF_FFFF);
    drive(1'b0, TXS_A, '0);
    n_checks++; if (bus.r_data !== 32'h2) begin n_fail++; $display("FAIL txstat_ovf_cleared: got %h expected %h", bus.r_data, 32'h2); end
    tx_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b;
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b1, TXD_A, 32'h51 + i);
    drive(1'b1, TXD_A, 32'h55);
    tx_ready = 1'b1;
    drive(1'b0, TXS_A, '0);
    tx_ready = 1'b0;
    n_checks++; if (bus.r_data !== 32'h011) begin n_fail++; $display("FAIL full_push_pop_stat: got %h expected %h", bus.r_data, 32'h011); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, TXD_A, '0);
      tx_ready = 1'b1;
      exp_b = 8'h52 + 8'(i);
      n_checks++; if (tx_valid !== 1'b1 || tx_data !== exp_b) begin n_fail++; $display("FAIL full_drain_%0d: got v=%b d=%h expected v=1 d=%h", i, tx_valid, tx_data, exp_b); end
    end
    drive(1'b0, TXS_A, '0);
    tx_ready = 1'b0;
    n_checks++; if (tx_valid !== 1'b0 || bus.r_data !== 32'h2) begin n_fail++; $display("FAIL full_drain_end: got v=%b stat=%h expected v=0 stat=%h", tx_valid, bus.r_data, 32'h2); end
    // Push and pop together at count 1.
    drive(1'b1, TXD_A, 32'h61);
    drive(1'b1, TXD_A, 32'h62);
    tx_ready = 1'b1;
    drive(1'b0, TXS_A, '0);
    tx_ready = 1'b0;
    n_checks++; if (bus.r_data !== 32'h4 || tx_data !== 8'h62) begin n_fail++; $display("FAIL count1_push_pop: got stat=%h d=%h expected stat=%h d=62", bus.r_data, tx_data, 32'h4); end
    drive(1'b0, TXD_A, '0);
    tx_ready = 1'b1;
    drive(1'b0, TXS_A, '0);
    tx_ready = 1'b0;
    n_checks++; if (bus.r_data !== 32'h2) begin n_fail++; $display("FAIL count1_final_pop: got %h expected %h", bus.r_data, 32'h2); end
  endtask

  task automatic test_cycle();
    drive(1'b1, CYC_A, 32'h1234_5678);
    drive(1'b0, CYC_A, '0);
    n_checks++; if (bus.r_data !== 32'd0) begin n_fail++; $display("FAIL cycle_after_store: got %h expected 0", bus.r_data); end
    drive(1'b0, CYC_A, '0);
    n_checks++; if (bus.r_data !== 32'd1) begin n_fail++; $display("FAIL cycle_increment: got %h expected 1", bus.r_data); end
    force dut.cycle_q = 32'hFFFF_FFFF;
    #1;
    n_checks++; if (bus.r_data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cycle_forced: got %h expected %h", bus.r_data, 32'hFFFF_FFFF); end
    n_checks++; if (dut.cycle_d !== 32'd0) begin n_fail++; $display("FAIL cycle_wrap_next: got %h expected 0", dut.cycle_d); end
    release dut.cycle_q;
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'h20, 32'h7777_7777);
    drive(1'b1, GPIO_A, 32'hA5A5_A5A5);
    tx_ready = 1'b0;
    for (int i = 1; i <= 3; i++) drive(1'b1, TXD_A, i);
    drive(1'b0, TXS_A, '0);
    n_checks++; if (bus.r_data !== 32'hC) begin n_fail++; $display("FAIL pre_reset_count3: got %h expected %h", bus.r_data, 32'hC); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_tx_valid: got %b expected 0", tx_valid); end
    n_checks++; if (gpio_out !== 32'h0) begin n_fail++; $display("FAIL midreset_gpio: got %h expected 0", gpio_out); end
    n_checks++; if (err_misaligned !== 1'b0) begin n_fail++; $display("FAIL midreset_err: got %b expected 0", err_misaligned); end
    n_checks++; if (bus.r_data !== 32'h2) begin n_fail++; $display("FAIL midreset_txstat: got %h expected %h", bus.r_data, 32'h2); end
    drive(1'b0, CYC_A, '0);
    n_checks++; if (bus.r_data !== 32'h0) begin n_fail++; $display("FAIL midreset_cycle: got %h expected 0", bus.r_data); end
    rst_n = 1'b1;
    drive(1'b0, 32'h20, '0);
    n_checks++; if (bus.r_data !== 32'h7777_7777) begin n_fail++; $display("FAIL ram_kept_0x20: got %h expected %h", bus.r_data, 32'h7777_7777); end
    drive(1'b0, 32'h10, '0);
    n_checks++; if (bus.r_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_kept_0x10: got %h expected %h", bus.r_data, 32'hDEAD_BEEF); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_gpio_misaligned();
    test_fifo_overflow();
    test_back_to_back();
    test_cycle();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
